// File: rtl/spi_mosi_burst_tx.sv
// Burst MOSI transmitter: 1..N words of WIDTH bits per load, selectable bit order and CS framing.
// All outputs registered; a burst request is accepted in IDLE or DONE and requests while busy are dropped.
module spi_mosi_burst_tx #(
  parameter int WIDTH = 8,
  parameter int N     = 16,
  parameter int CNT_W = 5
) (
  input  logic               i_SCK,
  input  logic               i_RST,
  input  logic [WIDTH*N-1:0] i_DATA,
  input  logic [N-1:0]       i_DC,
  input  logic [CNT_W-1:0]   i_N_transmit,
  input  logic               i_LSB_FIRST,
  input  logic               i_CS_TOGGLE,
  input  logic               i_START,
  output logic               o_MOSI,
  output logic               o_CS,
  output logic               o_DC,
  output logic               o_BUSY,
  output logic [CNT_W-1:0]   o_BYTE_IDX,
  output logic               o_FINAL_BIT,
  output logic               o_FINAL_BYTE,
  output logic               o_DONE
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t                   state;
  logic [BIT_W-1:0]         bit_cnt;
  logic [CNT_W-1:0]         last_idx;
  logic [N-1:0][WIDTH-1:0]  sh_data;
  logic [N-1:0]             sh_dc;
  logic                     sh_lsb;
  logic                     sh_tog;

  state_t                   nxt_state;
  logic [BIT_W-1:0]         nxt_bit;
  logic [CNT_W-1:0]         nxt_idx;
  logic [CNT_W-1:0]         nxt_last;
  logic [CNT_W-1:0]         eff_cnt;
  logic                     load;
  logic [N-1:0][WIDTH-1:0]  src_data;
  logic [N-1:0]             src_dc;
  logic                     src_lsb;
  logic [WIDTH-1:0]         src_word;
  logic [BIT_W-1:0]         sel;
  logic                     nxt_mosi;

  assign eff_cnt = (i_N_transmit > CNT_W'(N)) ? CNT_W'(N) : i_N_transmit;

  always_comb begin
    nxt_state = state;
    nxt_bit   = bit_cnt;
    nxt_idx   = o_BYTE_IDX;
    load      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        nxt_bit = '0;
        nxt_idx = '0;
        if (i_START && (i_N_transmit != '0)) begin
          load      = 1'b1;
          nxt_state = S_SHIFT;
        end else begin
          nxt_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          nxt_bit = '0;
          if (o_BYTE_IDX == last_idx) begin
            nxt_state = S_DONE;
            nxt_idx   = '0;
          end else if (sh_tog) begin
            nxt_state = S_GAP;
          end else begin
            nxt_idx = o_BYTE_IDX + CNT_W'(1);
          end
        end else begin
          nxt_bit = bit_cnt + BIT_W'(1);
        end
      end
      S_GAP: begin
        nxt_state = S_SHIFT;
        nxt_bit   = '0;
        nxt_idx   = o_BYTE_IDX + CNT_W'(1);
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // The first word of a burst is taken straight from the inputs, since the shadows load on the same edge.
  always_comb begin
    if (load) begin
      src_data = i_DATA;
      src_dc   = i_DC;
      src_lsb  = i_LSB_FIRST;
      nxt_last = eff_cnt - CNT_W'(1);
    end else begin
      src_data = sh_data;
      src_dc   = sh_dc;
      src_lsb  = sh_lsb;
      nxt_last = last_idx;
    end
    src_word = src_data[nxt_idx[IDX_W-1:0]];
    sel      = src_lsb ? nxt_bit : (LAST_BIT - nxt_bit);
    nxt_mosi = src_word[sel];
  end

  always_ff @(posedge i_SCK or negedge i_RST) begin
    if (!i_RST) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      last_idx     <= '0;
      sh_data      <= '0;
      sh_dc        <= '0;
      sh_lsb       <= 1'b0;
      sh_tog       <= 1'b0;
      o_MOSI       <= 1'b0;
      o_CS         <= 1'b1;
      o_DC         <= 1'b0;
      o_BUSY       <= 1'b0;
      o_BYTE_IDX   <= '0;
      o_FINAL_BIT  <= 1'b0;
      o_FINAL_BYTE <= 1'b0;
      o_DONE       <= 1'b0;
    end else begin
      state      <= nxt_state;
      bit_cnt    <= nxt_bit;
      o_BYTE_IDX <= nxt_idx;
      if (load) begin
        sh_data  <= i_DATA;
        sh_dc    <= i_DC;
        sh_lsb   <= i_LSB_FIRST;
        sh_tog   <= i_CS_TOGGLE;
        last_idx <= nxt_last;
      end
      o_MOSI <= (nxt_state == S_SHIFT) && nxt_mosi;
      o_CS   <= (nxt_state != S_SHIFT);
      // D/C only moves when a word starts shifting, so it holds through gaps.
      if (nxt_state == S_SHIFT)
        o_DC <= src_dc[nxt_idx[IDX_W-1:0]];
      o_BUSY       <= (nxt_state == S_SHIFT) || (nxt_state == S_GAP);
      o_FINAL_BIT  <= (nxt_state == S_SHIFT) && (nxt_bit == LAST_BIT);
      o_FINAL_BYTE <= (nxt_state == S_SHIFT) && (nxt_idx == nxt_last);
      o_DONE       <= (nxt_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_spi_mosi_burst_tx.sv
// Scoreboard bench for spi_mosi_burst_tx: stimulus queues expected per-cycle outputs, monitor pops and compares.
module tb_spi_mosi_burst_tx;

  localparam int WIDTH = 8;
  localparam int N     = 16;
  localparam int CNT_W = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH*N-1:0] i_data = '0;
  logic [N-1:0]       i_dc = '0;
  logic [CNT_W-1:0]   i_n = '0;
  logic               i_lsb = 1'b0;
  logic               i_tog = 1'b0;
  logic               i_start = 1'b0;
  logic               o_mosi, o_cs, o_dc, o_busy, o_fbit, o_fbyte, o_done;
  logic [CNT_W-1:0]   o_idx;

  always #5 clk = ~clk;

  spi_mosi_burst_tx #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
    .i_SCK(clk), .i_RST(rst_n), .i_DATA(i_data), .i_DC(i_dc),
    .i_N_transmit(i_n), .i_LSB_FIRST(i_lsb), .i_CS_TOGGLE(i_tog), .i_START(i_start),
    .o_MOSI(o_mosi), .o_CS(o_cs), .o_DC(o_dc), .o_BUSY(o_busy),
    .o_BYTE_IDX(o_idx), .o_FINAL_BIT(o_fbit), .o_FINAL_BYTE(o_fbyte), .o_DONE(o_done)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cs;
    logic       mosi;
    logic       dc;
    logic [4:0] idx;
    logic       fbit;
    logic       fbyte;
  } obs_t;

  typedef struct packed {
    obs_t val;
    obs_t msk;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  int   cs_low_cnt, busy_cnt, done_cnt, max_idx, gap_n, bits_seen;
  int   gap_pos [2];
  logic [7:0] first8;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input obs_t v, input bit dc_care);
    exp_t e;
    e.val = v;
    e.msk = '1;
    if (!dc_care) e.msk.dc = 1'b0;
    sb.push_back(e);
  endtask

  // Expected cycle-by-cycle response of one burst.
  task automatic push_burst(input logic [127:0] d, input logic [15:0] dc, input int n_req,
                            input bit lsb, input bit tog);
    int n;
    logic [7:0] w;
    obs_t v;
    n = (n_req > N) ? N : n_req;
    if (n == 0) return;
    for (int k = 0; k < n; k++) begin
      w = d[k*8 +: 8];
      for (int b = 0; b < 8; b++) begin
        v.busy = 1'b1; v.done = 1'b0; v.cs = 1'b0;
        v.mosi = lsb ? w[b] : w[7-b];
        v.dc = dc[k]; v.idx = 5'(k);
        v.fbit = (b == 7); v.fbyte = (k == n - 1);
        push_exp(v, 1'b1);
      end
      if (tog && k != n - 1) begin
        v.busy = 1'b1; v.done = 1'b0; v.cs = 1'b1; v.mosi = 1'b0;
        v.dc = dc[k]; v.idx = 5'(k); v.fbit = 1'b0; v.fbyte = 1'b0;
        push_exp(v, 1'b1);
      end
    end
    v.busy = 1'b0; v.done = 1'b1; v.cs = 1'b1; v.mosi = 1'b0;
    v.dc = 1'b0; v.idx = '0; v.fbit = 1'b0; v.fbyte = 1'b0;
    push_exp(v, 1'b0);
  endtask

  always @(negedge clk) begin
    obs_t o;
    exp_t e;
    if (mon_en) begin
      o = {o_busy, o_done, o_cs, o_mosi, o_dc, o_idx, o_fbit, o_fbyte};
      if (o_busy || o_done) begin
        if (o_busy) busy_cnt++;
        if (o_done) done_cnt++;
        if (!o_cs) begin
          cs_low_cnt++;
          if (bits_seen < 8) first8 = {first8[6:0], o_mosi};
          bits_seen++;
        end else if (o_busy && gap_n < 2) begin
          gap_pos[gap_n] = busy_cnt;
          gap_n++;
        end
        if (int'(o_idx) > max_idx) max_idx = int'(o_idx);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_output act=%h req=none", o);
        end else begin
          e = sb.pop_front();
          if ((o & e.msk) !== (e.val & e.msk)) begin
            bad++;
            $display("FAIL scoreboard act=%h req=%h (busy,done,cs,mosi,dc,idx,fbit,fbyte)", o, e.val);
          end
        end
      end
    end
  end

  task automatic clear_stats();
    cs_low_cnt = 0; busy_cnt = 0; done_cnt = 0; max_idx = 0;
    gap_n = 0; bits_seen = 0; first8 = '0; gap_pos[0] = 0; gap_pos[1] = 0;
  endtask

  // Called just after a rising edge; START is sampled on the next edge.
  task automatic start_burst(input logic [127:0] d, input logic [15:0] dc, input int n,
                             input bit lsb, input bit tog);
    i_data = d; i_dc = dc; i_n = n[4:0]; i_lsb = lsb; i_tog = tog; i_start = 1'b1;
    push_burst(d, dc, n, lsb, tog);
    @(posedge clk); #1;
    i_start = 1'b0;
    i_data = ~d; i_dc = ~dc; i_lsb = ~lsb; i_tog = ~tog; i_n = '0;
    if (n != 0) begin
      chk("latency_busy", int'(o_busy), 1);
      chk("latency_cs", int'(o_cs), 0);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    obs_t idle_obs;
    int   seen;
    idle_obs = '0;
    idle_obs.cs = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({o_busy, o_done, o_cs, o_mosi, o_dc, o_idx, o_fbit, o_fbyte}), int'(idle_obs));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort mid-word: reset lands during bit 3 of word 0.
    clear_stats();
    start_burst(128'h0000_00A5, 16'h0003, 2, 1'b0, 1'b0);
    sb.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", int'({o_busy, o_done, o_cs, o_mosi, o_dc, o_idx, o_fbit, o_fbyte}), int'(idle_obs));
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (o_done) seen++; end
    rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (o_done || o_busy) seen++; end
    chk("abort_no_done", seen, 0);
    mon_en = 1'b1;

    // Single word, MSB first.
    clear_stats();
    start_burst(128'hA5, 16'h0001, 1, 1'b0, 1'b0);
    drain("a5_drain");
    chk("a5_bits", int'(first8), 8'hA5);
    chk("a5_cs_low", cs_low_cnt, 8);
    chk("a5_done", done_cnt, 1);

    // Three words, LSB first, CS held.
    clear_stats();
    start_burst(128'hFF_80_01, 16'b110, 3, 1'b1, 1'b0);
    drain("lsb_held_drain");
    chk("lsb_held_cs_low", cs_low_cnt, 24);
    chk("lsb_held_busy", busy_cnt, 24);
    chk("lsb_held_word0", int'(first8), 8'h80);
    chk("lsb_held_max_idx", max_idx, 2);
    chk("lsb_held_gaps", gap_n, 0);

    // Same words, CS toggled between words.
    clear_stats();
    start_burst(128'hFF_80_01, 16'b110, 3, 1'b1, 1'b1);
    drain("tog_drain");
    chk("tog_cs_low", cs_low_cnt, 24);
    chk("tog_span", busy_cnt, 26);
    chk("tog_gap_count", gap_n, 2);
    chk("tog_gap0_pos", gap_pos[0], 9);
    chk("tog_gap1_pos", gap_pos[1], 18);

    // Zero-length request is ignored.
    clear_stats();
    start_burst(128'hFF, 16'hFFFF, 0, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    chk("n0_busy", busy_cnt, 0);
    chk("n0_done", done_cnt, 0);

    // Over-length request is clipped to N words; a START mid-burst is dropped.
    clear_stats();
    start_burst(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 16'hA5C3, 20, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    i_data = 128'h55; i_n = 5'd1; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    drain("n20_drain");
    chk("n20_cs_low", cs_low_cnt, 128);
    chk("n20_max_idx", max_idx, 15);
    chk("n20_done", done_cnt, 1);

    // Back-to-back: new START issued in the DONE cycle.
    clear_stats();
    start_burst(128'h5A, 16'h0000, 1, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !o_done; i++) begin @(posedge clk); #1; end
    chk("b2b_done_seen", int'(o_done), 1);
    i_data = 128'h3C; i_dc = 16'h0001; i_n = 5'd1; i_lsb = 1'b0; i_tog = 1'b0; i_start = 1'b1;
    push_burst(128'h3C, 16'h0001, 1, 1'b0, 1'b0);
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("b2b_no_idle_busy", int'(o_busy), 1);
    chk("b2b_no_idle_cs", int'(o_cs), 0);
    drain("b2b_drain");
    chk("b2b_cs_low", cs_low_cnt, 16);
    chk("b2b_done", done_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
